// File: rtl/mac_seq_pkg.sv
// Shared types for the MAC operand sequencer: FSM states, operand/result widths
// and the FIFO entry layout.
package mac_seq_pkg;

  localparam int unsigned OPW  = 8;
  localparam int unsigned RESW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StWaitHi,
    StWaitLo,
    StSettle,
    StResult
  } state_e;

  typedef struct packed {
    logic           last;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } fifo_entry_t;

endpackage

// File: rtl/mac_seq_fifo.sv
// Synchronous DEPTH-entry FIFO with show-ahead head for operand pairs.
// Push is ignored when full and pop is ignored when empty.
module mac_seq_fifo
  import mac_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] DepthCnt = AW'(0) + (AW + 1)'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array, no reset needed: contents are only read when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Drives an 8x8 MAC from a stream of operand pairs: clears the accumulator at the
// start of each frame, issues one multiply per pair and returns the frame sum.
// Optional watchdog on the busy wait is enabled with `define MAC_TIMEOUT_EN.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_a,
  input  logic [OPW-1:0]  in_b,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RESW-1:0] out_result,
  output logic            out_overflow,
  output logic            out_timeout,
  output logic [OPW-1:0]  mac_a,
  output logic [OPW-1:0]  mac_b,
  output logic            mac_set_b,
  output logic            mac_clr,
  input  logic            mac_busy,
  input  logic [RESW-1:0] mac_o,
  input  logic            mac_overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_timeout_check
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e          state_q, state_d;
  logic            first_q, first_d;
  logic            hi_seen_q, hi_seen_d;
  logic [OPW-1:0]  mac_a_q, mac_b_q;
  logic [RESW-1:0] result_q;
  logic            ovf_q;
  logic            pop;
  logic            capture;
  logic            timeout_fire;
  fifo_entry_t     in_entry;
  fifo_entry_t     head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign in_entry = '{last: in_last, a: in_a, b: in_b};
  assign in_ready = !fifo_full;

  mac_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef MAC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt_q;
  logic          to_q;

  assign timeout_fire = (state_q == StWaitHi || state_q == StWaitLo) &&
                        (to_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign out_timeout  = to_q;

  // Watchdog: counts cycles spent waiting on the MAC; sticky flag lasts until handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (state_q == StLoad) begin
        to_cnt_q <= '0;
      end else if (state_q == StWaitHi || state_q == StWaitLo) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (state_q == StResult && out_ready) begin
        to_q <= 1'b0;
      end else if (timeout_fire) begin
        to_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign out_timeout  = 1'b0;
`endif

  // Next-state and one-cycle MAC strobes.
  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    hi_seen_d = hi_seen_q;
    pop       = 1'b0;
    capture   = 1'b0;
    mac_clr   = 1'b0;
    mac_set_b = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = first_q ? StClear : StLoad;
      end
      StClear: begin
        mac_clr = 1'b1;
        first_d = 1'b0;
        state_d = StLoad;
      end
      StLoad: begin
        mac_set_b = 1'b1;
        hi_seen_d = 1'b0;
        state_d   = StWaitHi;
      end
      StWaitHi: begin
        // A MAC that never raises busy has finished after two quiet cycles.
        if (timeout_fire)   state_d = StSettle;
        else if (mac_busy)  state_d = StWaitLo;
        else if (hi_seen_q) state_d = StSettle;
        else                hi_seen_d = 1'b1;
      end
      StWaitLo: begin
        if (timeout_fire || !mac_busy) state_d = StSettle;
      end
      StSettle: begin
        // The MAC accumulates on the negedge inside this cycle, so mac_o is final here.
        pop = 1'b1;
        if (head.last) begin
          capture = 1'b1;
          state_d = StResult;
        end else if (fifo_count > CW'(1)) begin
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StResult: begin
        if (out_ready) begin
          first_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, held MAC operands and captured frame result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      first_q   <= 1'b1;
      hi_seen_q <= 1'b0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      hi_seen_q <= hi_seen_d;
      if (state_q == StLoad) begin
        mac_a_q <= head.a;
        mac_b_q <= head.b;
      end
      if (capture) begin
        result_q <= mac_o;
        ovf_q    <= mac_overflow;
      end
    end
  end

  // Operands come straight from the FIFO head during LOAD so they are valid with the
  // set_b pulse, then stay held in registers until the next LOAD.
  assign mac_a        = (state_q == StLoad) ? head.a : mac_a_q;
  assign mac_b        = (state_q == StLoad) ? head.b : mac_b_q;
  assign out_valid    = (state_q == StResult);
  assign out_result   = result_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a behavioural 8x8 MAC model.
// Timeout scenario runs only when MAC_TIMEOUT_EN is defined.
module tb_mac_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_timeout;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_set_b;
  logic        mac_clr;
  logic        mac_busy;
  logic [15:0] mac_o;
  logic        mac_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int setb_cnt = 0;
  int clr_cnt  = 0;

  // MAC model controls
  int          busy_len   = 0;
  logic        stuck      = 1'b0;
  logic        ovf_inject = 1'b0;
  logic [15:0] acc;
  logic        acc_ovf;
  logic [15:0] prod;
  logic [16:0] sum;
  int          busy_cnt;
  logic        pending;

  mac_operand_sequencer #(
    .DEPTH       (4),
    .TIMEOUT_CYC (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_timeout  (out_timeout),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_set_b    (mac_set_b),
    .mac_clr      (mac_clr),
    .mac_busy     (mac_busy),
    .mac_o        (mac_o),
    .mac_overflow (mac_overflow)
  );

  always #5 clk = ~clk;

  // MAC model: latch product on set_b, stay busy busy_len cycles, then accumulate.
  assign sum          = {acc[15], acc} + {prod[15], prod};
  assign mac_busy     = (busy_cnt > 0) || (stuck && pending);
  assign mac_o        = acc;
  assign mac_overflow = acc_ovf | ovf_inject;

  always @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      acc_ovf  <= 1'b0;
      prod     <= '0;
      busy_cnt <= 0;
      pending  <= 1'b0;
    end else begin
      if (mac_clr) begin
        acc     <= '0;
        acc_ovf <= 1'b0;
      end
      if (mac_set_b) begin
        prod     <= 16'($signed(mac_a) * $signed(mac_b));
        busy_cnt <= busy_len;
        pending  <= 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
      end else if (pending && !stuck) begin
        acc     <= sum[15:0];
        acc_ovf <= acc_ovf | (sum[16] ^ sum[15]);
        pending <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mac_set_b) setb_cnt <= setb_cnt + 1;
    if (mac_clr)   clr_cnt  <= clr_cnt + 1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(logic [7:0] a, logic [7:0] b, logic last);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic get_result(string tag, logic [15:0] er, logic eo, logic et);
    logic prev_ready;
    wait_valid(tag);
    check({tag, "_res"}, 32'(out_result), 32'(er));
    check({tag, "_ovf"}, 32'(out_overflow), 32'(eo));
    check({tag, "_to"}, 32'(out_timeout), 32'(et));
    prev_ready = out_ready;
    out_ready  = 1'b1;
    @(negedge clk);
    out_ready  = prev_ready;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_result"}, 32'(out_result), 0);
    check({tag, "_out_ovf"}, 32'(out_overflow), 0);
    check({tag, "_out_to"}, 32'(out_timeout), 0);
    check({tag, "_set_b"}, 32'(mac_set_b), 0);
    check({tag, "_clr"}, 32'(mac_clr), 0);
    check({tag, "_mac_a"}, 32'(mac_a), 0);
    check({tag, "_mac_b"}, 32'(mac_b), 0);
  endtask

  initial begin
    int s0;
    int c0;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // 1: three-pair frame, 4-cycle busy: 12 - 10 + 100 = 102
    busy_len = 4;
    s0 = setb_cnt;
    c0 = clr_cnt;
    push(8'd3, 8'd4, 1'b0);
    push(8'hFE, 8'd5, 1'b0);
    push(8'd10, 8'd10, 1'b1);
    get_result("t1", 16'h0066, 1'b0, 1'b0);
    check("t1_setb", 32'(setb_cnt - s0), 3);
    check("t1_clr", 32'(clr_cnt - c0), 1);

    // 2: back-to-back single-pair frames, fast-path MAC, ready held high
    busy_len  = 0;
    out_ready = 1'b1;
    s0 = setb_cnt;
    c0 = clr_cnt;
    push(8'd1, 8'd1, 1'b1);
    push(8'd2, 8'd2, 1'b1);
    get_result("t2a", 16'd1, 1'b0, 1'b0);
    get_result("t2b", 16'd4, 1'b0, 1'b0);
    check("t2_setb", 32'(setb_cnt - s0), 2);
    check("t2_clr", 32'(clr_cnt - c0), 2);
    out_ready = 1'b0;

    // 3: result stalled while the FIFO fills; no issue until handoff
    busy_len = 1;
    push(8'd2, 8'd2, 1'b1);
    wait_valid("t3");
    push(8'd1, 8'd2, 1'b0);
    push(8'd1, 8'd3, 1'b0);
    push(8'd1, 8'd4, 1'b0);
    push(8'd1, 8'd5, 1'b1);
    s0 = setb_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_res", 32'(out_result), 4);
    end
    check("t3_in_ready", 32'(in_ready), 0);
    check("t3_no_setb", 32'(setb_cnt - s0), 0);
    get_result("t3a", 16'd4, 1'b0, 1'b0);
    get_result("t3b", 16'd14, 1'b0, 1'b0);

    // 4: overflow reported by MAC: 127*127*2 = 32258
    busy_len   = 2;
    ovf_inject = 1'b1;
    push(8'd127, 8'd127, 1'b0);
    push(8'd127, 8'd127, 1'b1);
    get_result("t4", 16'd32258, 1'b1, 1'b0);
    ovf_inject = 1'b0;

    // 5: reset during WAIT_LO of pair 2, then a fresh frame
    busy_len = 4;
    s0 = setb_cnt;
    push(8'd2, 8'd3, 1'b0);
    push(8'd4, 8'd5, 1'b1);
    n = 0;
    while (setb_cnt - s0 < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_pair2", 32'(setb_cnt - s0), 2);
    repeat (2) @(negedge clk);
    check("t5_busy", 32'(mac_busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    c0 = clr_cnt;
    push(8'd5, 8'd5, 1'b1);
    get_result("t5", 16'd25, 1'b0, 1'b0);
    check("t5_clr", 32'(clr_cnt - c0), 1);

`ifdef MAC_TIMEOUT_EN
    // 6: busy stuck high; watchdog forces completion
    stuck = 1'b1;
    push(8'd1, 8'd1, 1'b1);
    get_result("t6", 16'd0, 1'b0, 1'b1);
    check("t6_to_cleared", 32'(out_timeout), 0);
    stuck = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
